// File: rtl/md_ctrl.sv
// md_ctrl: sequencing controller for the MIPS multiply/divide unit.
// Latches one MULT/MULTU/DIV/DIVU command, holds busy for a fixed latency,
// then commits the result to HI/LO. MTHI/MTLO write HI/LO immediately.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_ovf;
  logic        [31:0] b_div;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic        [31:0] uq;
  logic        [31:0] ur;

  // Result datapath from latched operands; a zero or overflowing divisor is
  // replaced by 1 so the dividers never see an undefined case (0x80000000/1
  // is exactly the required overflow result, and zero-divisor results are
  // discarded at commit).
  always_comb begin
    sa64    = $signed({{32{a_q[31]}}, a_q});
    sb64    = $signed({{32{b_q[31]}}, b_q});
    prod_s  = sa64 * sb64;
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    b_div   = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
    sq      = $signed(a_q) / $signed(b_div);
    sr      = $signed(a_q) % $signed(b_div);
    uq      = a_q / b_div;
    ur      = a_q % b_div;
  end

  // Control FSM, operand latches, latency counter and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= CNT_W'(MULT_CYCLES);
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= CNT_W'(DIV_CYCLES);
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_MTHI: hi <= A;
              OP_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            case (op_q)
              OP_MULT:  {hi, lo} <= prod_s;
              OP_MULTU: {hi, lo} <= prod_u;
              OP_DIV: begin
                if (b_q != 32'd0) begin
                  lo <= sq;
                  hi <= sr;
                end
              end
              OP_DIVU: begin
                if (b_q != 32'd0) begin
                  lo <= uq;
                  hi <= ur;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and randomized checks of md_ctrl against an
// arithmetic reference model of HI/LO and the busy latency.
module tb_md_ctrl;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference semantics of one committed command on the architectural HI/LO.
  function automatic void model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, aa, ab, q, r;
    longint unsigned ua, ub, up;
    case (c)
      3'd0: begin
        sa = $signed(a); sb = $signed(b);
        q = sa * sb;
        exp_hi = q[63:32]; exp_lo = q[31:0];
      end
      3'd1: begin
        ua = a; ub = b; up = ua * ub;
        exp_hi = up[63:32]; exp_lo = up[31:0];
      end
      3'd2: if (b != 0) begin
        sa = $signed(a); sb = $signed(b);
        aa = (sa < 0) ? -sa : sa;
        ab = (sb < 0) ? -sb : sb;
        q = aa / ab; r = aa % ab;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        exp_lo = q[31:0]; exp_hi = r[31:0];
      end
      3'd3: if (b != 0) begin
        ua = a; ub = b;
        exp_lo = 32'(ua / ub); exp_hi = 32'(ua % ub);
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Issue a command in the current cycle (called #1 after an edge) and
  // follow it to completion; perturb drives junk on A/B/start during RUN.
  task automatic run_cmd(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit perturb);
    int unsigned lat;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi; old_lo = exp_lo;
    lat = (c <= 3'd1) ? MC : ((c <= 3'd3) ? DC : 0);
    start = 1'b1; op = c; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(lat); i++) begin
      check($sformatf("busy_run op%0d cyc%0d", c, i), 64'(busy), 64'd1);
      check($sformatf("hold op%0d cyc%0d", c, i), {hi, lo}, {old_hi, old_lo});
      if (perturb) begin
        A = $urandom; B = $urandom;
        start = ($urandom_range(0, 2) == 0);
        op = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    model(c, a, b);
    check($sformatf("busy_done op%0d", c), 64'(busy), 64'd0);
    check($sformatf("result op%0d a=%0h b=%0h", c, a, b), {hi, lo}, {exp_hi, exp_lo});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);

    // Directed cases from the plan.
    run_cmd(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_cmd(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_cmd(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_cmd(3'd3, 32'd7, 32'd2, 1'b0);
    check("divu const", {hi, lo}, 64'h0000_0001_0000_0003);
    run_cmd(3'd4, 32'h1234, 32'd0, 1'b0);
    run_cmd(3'd5, 32'h5678, 32'd0, 1'b0);
    check("mthi/mtlo const", {hi, lo}, 64'h0000_1234_0000_5678);
    run_cmd(3'd3, 32'd7, 32'd0, 1'b0);
    check("divu by zero const", {hi, lo}, 64'h0000_1234_0000_5678);
    run_cmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_cmd(3'd6, 32'hDEAD, 32'd1, 1'b0);
    run_cmd(3'd7, 32'hBEEF, 32'd1, 1'b0);

    // Ignored MTHI and DIV during a MULT, with operands moving.
    begin
      start = 1'b1; op = 3'd0; A = 32'd1000; B = 32'd1000;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd4; A = 32'hAAAA; B = 32'd9;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd2; A = 32'd77; B = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; A = $urandom; B = $urandom;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ignored busy last", 64'(busy), 64'd1);
      @(posedge clk); #1;
      check("ignored busy drop", 64'(busy), 64'd0);
      check("ignored result", {hi, lo}, 64'd1000000);
      exp_hi = 32'd0; exp_lo = 32'd1000000;
    end

    // Reset on the third busy cycle of a DIV.
    begin
      start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre-reset busy", 64'(busy), 64'd1);
      do_reset();
      check("midrun reset busy", 64'(busy), 64'd0);
      check("midrun reset hilo", {hi, lo}, 64'd0);
      run_cmd(3'd0, 32'd3, 32'd4, 1'b0);
      check("post-reset mult", {hi, lo}, 64'd12);
    end

    // Back-to-back: second command starts in the first non-busy cycle.
    run_cmd(3'd0, 32'd2, 32'd3, 1'b0);
    run_cmd(3'd1, 32'd5, 32'd5, 1'b0);
    check("b2b second", {hi, lo}, 64'd25);

    // Randomized commands with perturbation during RUN.
    for (int k = 0; k < 150; k++) begin
      run_cmd(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
